// File: rtl/img_buf_ctrl_pkg.sv
// Shared constants, FSM state encoding and nibble-slot helper for the image buffer sequencer.
package img_buf_ctrl_pkg;

  localparam int IMG_PIXELS_DEF = 4096;
  localparam int ADDR_W_DEF     = 12;
  localparam int PIX_W_DEF      = 4;
  localparam int NIBS_PER_WORD  = 8;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_SHOW   = 2'd2
  } state_t;

  // Within each byte the high nibble goes out first, bytes in ascending order.
  function automatic logic [2:0] nib_slot(input logic [2:0] cnt);
    return {cnt[2:1], ~cnt[0]};
  endfunction

endpackage

// File: rtl/img_buf_ctrl_nibble_unpacker.sv
// Holds one packed word and steps through its eight pixel nibbles, flagging the last one.
module img_buf_ctrl_nibble_unpacker
  import img_buf_ctrl_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int WORD_W = NIBS_PER_WORD * PIX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              run,
  output logic [PIX_W-1:0]  nib,
  output logic [2:0]        nib_cnt,
  output logic              last
);

  logic [WORD_W-1:0] word_p0;

  always_ff @(posedge clk) begin
    if (load) word_p0 <= word_in;
  end

  always_ff @(posedge clk) begin
    if (reset)     nib_cnt <= '0;
    else if (load) nib_cnt <= '0;
    else if (run)  nib_cnt <= nib_cnt + 3'd1;
  end

  assign nib  = word_p0[int'(nib_slot(nib_cnt)) * PIX_W +: PIX_W];
  assign last = run && (nib_cnt == 3'd7);

endmodule

// File: rtl/img_buf_ctrl.sv
// Image buffer sequencer: load packed words into the pixel buffer, then stream it to the VGA scan.
// Build option IMG_BUF_CTRL_BLANK_EN: drive pix_value to 0 whenever pix_valid is low.
module img_buf_ctrl
  import img_buf_ctrl_pkg::*;
#(
  parameter int IMG_PIXELS = IMG_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int PIX_W      = PIX_W_DEF,
  parameter int WORD_W     = NIBS_PER_WORD * PIX_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic              reload,
  input  logic              active,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata,
  output logic [PIX_W-1:0]  pix_value,
  output logic              pix_valid,
  output logic              img_ready,
  output logic              frame_done
);

  localparam logic [ADDR_W:0]   IMG_END   = (ADDR_W + 1)'(IMG_PIXELS);
  localparam logic [ADDR_W:0]   WORD_STEP = (ADDR_W + 1)'(NIBS_PER_WORD);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  state_t            state_q, state_nxt;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              reload_pend;
  logic              vld_p1;
  logic [PIX_W-1:0]  nib;
  logic [2:0]        nib_cnt;
  logic              nib_last;
  logic              handshake, rd_fire_p0, last_rd, go_load, img_full;
  logic [ADDR_W:0]   wr_sum;

  assign handshake  = word_valid && (state_q == ST_LOAD);
  assign rd_fire_p0 = active && (state_q == ST_SHOW);
  assign last_rd    = rd_fire_p0 && (rd_ptr == LAST_ADDR);
  assign wr_sum     = {1'b0, wr_ptr} + WORD_STEP;
  assign img_full   = (wr_sum == IMG_END);
  // A queued or fresh reload waits for the frame boundary, or acts at once when idle at pixel 0.
  assign go_load    = (state_q == ST_SHOW) && (reload_pend || reload) &&
                      (last_rd || ((rd_ptr == '0) && !active));

  img_buf_ctrl_nibble_unpacker #(
    .PIX_W  (PIX_W),
    .WORD_W (WORD_W)
  ) u_unpacker (
    .clk     (clk),
    .reset   (reset),
    .load    (handshake),
    .word_in (word_in),
    .run     (state_q == ST_UNPACK),
    .nib     (nib),
    .nib_cnt (nib_cnt),
    .last    (nib_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_LOAD;
    else       state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_LOAD:   if (handshake) state_nxt = ST_UNPACK;
      ST_UNPACK: if (nib_last)  state_nxt = img_full ? ST_SHOW : ST_LOAD;
      ST_SHOW:   if (go_load)   state_nxt = ST_LOAD;
      default:                  state_nxt = ST_LOAD;
    endcase
  end

  always_comb begin
    word_ready = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    frame_done = 1'b0;
    case (state_q)
      ST_LOAD:   word_ready = 1'b1;
      ST_UNPACK: begin
        mem_we   = 1'b1;
        mem_addr = wr_ptr + ADDR_W'(nib_cnt);
      end
      ST_SHOW:   begin
        mem_addr   = rd_ptr;
        frame_done = last_rd;
      end
      default:   word_ready = 1'b0;
    endcase
  end

  assign mem_wdata = nib;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      reload_pend <= 1'b0;
      img_ready   <= 1'b0;
    end else if (go_load) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      reload_pend <= 1'b0;
      img_ready   <= 1'b0;
    end else begin
      if (nib_last) begin
        wr_ptr <= img_full ? '0 : wr_sum[ADDR_W-1:0];
        if (img_full) img_ready <= 1'b1;
      end
      if (rd_fire_p0) rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
      if ((state_q == ST_SHOW) && reload) reload_pend <= 1'b1;
    end
  end

  // Read return stage: memory data arrives the cycle after the address was issued.
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= rd_fire_p0;
  end

  assign pix_valid = vld_p1;

`ifdef IMG_BUF_CTRL_BLANK_EN
  assign pix_value = vld_p1 ? mem_rdata : '0;
`else
  logic [PIX_W-1:0] pix_hold_p1;

  always_ff @(posedge clk) begin
    if (reset)       pix_hold_p1 <= '0;
    else if (vld_p1) pix_hold_p1 <= mem_rdata;
  end

  assign pix_value = vld_p1 ? mem_rdata : pix_hold_p1;
`endif

endmodule

// File: tb/tb_img_buf_ctrl.sv
// Directed bench for img_buf_ctrl with a behavioural 4096x4 synchronous-read buffer.
module tb_img_buf_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        word_ready;
  logic        reload = 1'b0;
  logic        active = 1'b0;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_wdata;
  logic [3:0]  mem_rdata = '0;
  logic [3:0]  pix_value;
  logic        pix_valid;
  logic        img_ready;
  logic        frame_done;

  int n_err = 0;
  int n_chk = 0;

  logic [3:0] mem [0:4095];

  always #5 clk = ~clk;

  img_buf_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .word_in    (word_in),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .reload     (reload),
    .active     (active),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .pix_value  (pix_value),
    .pix_valid  (pix_valid),
    .img_ready  (img_ready),
    .frame_done (frame_done)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Words whose nibbles land so that buffer[a] == a[3:0].
  task automatic load_image(input bit hold_reload);
    int hs = 0;
    int cyc = 0;
    int last_cyc = 0;
    bit first_seen = 0;
    bit done = 0;
    while (!done && cyc < 6000) begin
      step();
      word_valid = 1'b1;
      word_in    = hs[0] ? 32'hEFCDAB89 : 32'h67452301;
      reload     = hold_reload && (hs < 512);
      @(negedge clk);
      if (mem_we && !first_seen) begin
        first_seen = 1;
        chk("first_wr_addr", 32'(mem_addr), 0);
      end
      if (img_ready) done = 1;
      else if (word_ready) begin
        if (hs > 0) chk("hs_gap", cyc - last_cyc, 9);
        last_cyc = cyc;
        hs++;
      end
      cyc++;
    end
    reload = 1'b0;
    chk("hs_count", hs, 512);
    chk("img_ready_after_load", 32'(img_ready), 1);
    chk("ready_latency", cyc - 1 - last_cyc, 9);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("show_word_ready", 32'(word_ready), 0);
    end
    word_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] exp_nib [8];
    int cnt;
    bit seen;
    exp_nib = '{4'hD, 4'h4, 4'hC, 4'h3, 4'hB, 4'h2, 4'hA, 4'h1};

    // Reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_word_ready", 32'(word_ready), 1);
    chk("rst_img_ready", 32'(img_ready), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_pix_value", 32'(pix_value), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);

    // Single word unpack order
    step();
    reset = 1'b0;
    word_valid = 1'b1;
    word_in = 32'hA1B2C3D4;
    @(negedge clk);
    chk("t2_ready", 32'(word_ready), 1);
    for (int k = 0; k < 8; k++) begin
      step();
      word_valid = 1'b0;
      @(negedge clk);
      chk("t2_we", 32'(mem_we), 1);
      chk("t2_addr", 32'(mem_addr), k);
      chk("t2_wdata", 32'(mem_wdata), 32'(exp_nib[k]));
      chk("t2_ready_busy", 32'(word_ready), 0);
    end
    step();
    @(negedge clk);
    chk("t2_ready_back", 32'(word_ready), 1);
    chk("t2_we_off", 32'(mem_we), 0);

    // Full image load with word_valid held high
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_image(1'b0);

    // Continuous display across a frame wrap
    for (int i = 0; i < 4100; i++) begin
      step();
      active = 1'b1;
      @(negedge clk);
      chk("t4_addr", 32'(mem_addr), i % 4096);
      chk("t4_frame_done", 32'(frame_done), 32'((i % 4096) == 4095));
      chk("t4_pix_valid", 32'(pix_valid), 32'(i > 0));
      if (i > 0) chk("t4_pix_value", 32'(pix_value), ((i - 1) % 4096) & 15);
    end
    step();
    active = 1'b0;
    @(negedge clk);
    chk("t4_tail_valid", 32'(pix_valid), 1);
    chk("t4_tail_value", 32'(pix_value), 3);
    chk("t4_idle_fd", 32'(frame_done), 0);
    step();
    @(negedge clk);
    chk("t4_gap_valid", 32'(pix_valid), 0);
`ifdef IMG_BUF_CTRL_BLANK_EN
    chk("t4_gap_value", 32'(pix_value), 0);
`else
    chk("t4_gap_value", 32'(pix_value), 3);
`endif

    // Reload pulse mid-frame completes the frame first
    for (int k = 0; k < 96; k++) begin
      step();
      active = 1'b1;
    end
    step();
    reload = 1'b1;
    @(negedge clk);
    chk("t5_reload_addr", 32'(mem_addr), 100);
    cnt = 0;
    seen = 0;
    while (!seen && cnt < 5000) begin
      step();
      reload = 1'b0;
      @(negedge clk);
      cnt++;
      if (frame_done) begin
        seen = 1;
        chk("t5_fd_addr", 32'(mem_addr), 4095);
      end else if (!img_ready) begin
        chk("t5_img_ready_early", 32'(img_ready), 1);
        cnt = 5000;
      end
    end
    chk("t5_fd_cycles", cnt, 3995);
    step();
    @(negedge clk);
    chk("t5_img_ready", 32'(img_ready), 0);
    chk("t5_word_ready", 32'(word_ready), 1);
    chk("t5_inflight_valid", 32'(pix_valid), 1);
    chk("t5_inflight_value", 32'(pix_value), 15);
    step();
    @(negedge clk);
    chk("t5_load_no_read", 32'(pix_valid), 0);
`ifdef IMG_BUF_CTRL_BLANK_EN
    chk("t5_load_value", 32'(pix_value), 0);
`else
    chk("t5_load_value", 32'(pix_value), 15);
`endif
    active = 1'b0;

    // Reset in the middle of an unpack
    step();
    word_valid = 1'b1;
    word_in = 32'h12345678;
    @(negedge clk);
    chk("t6_ready", 32'(word_ready), 1);
    for (int k = 0; k < 4; k++) begin
      step();
      word_valid = 1'b0;
      if (k == 3) reset = 1'b1;
      @(negedge clk);
      chk("t6_wr_addr", 32'(mem_addr), k);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_we_off", 32'(mem_we), 0);
    chk("t6_word_ready", 32'(word_ready), 1);
    chk("t6_img_ready", 32'(img_ready), 0);
    load_image(1'b1);

    // Reload raised during loading must not have been queued
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk);
      chk("t6_no_queued_reload", 32'(img_ready), 1);
    end
    step();
    reload = 1'b1;
    @(negedge clk);
    chk("t6_reload_cycle", 32'(img_ready), 1);
    step();
    reload = 1'b0;
    @(negedge clk);
    chk("t6_idle_reload_img", 32'(img_ready), 0);
    chk("t6_idle_reload_rdy", 32'(word_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
